// File: rtl/pipe_pkg.sv
// Shared definitions for the WISC-SP22 pipeline stall/flush sequencer.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DRAIN  = 2'b01,
    HALTED = 2'b10
  } state_t;

  // Instruction word loaded into IF/ID when it is flushed
  localparam logic [15:0] NOP_INSTR = 16'h0800;

  localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter for pipeline performance statistics.
module sat_counter #(
  parameter int CNT_W = pipe_pkg::CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer: per-stage enables, NOP-insert controls, halt drain
// and performance counters for the 5-stage pipeline.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEF,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_stall,
  input  logic             branchJumpDTaken_ID,
  input  logic             halt_ID,
  input  logic             imem_stall,
  input  logic             dmem_stall,
  input  logic             err,
  output logic             PC_en,
  output logic             IFID_en,
  output logic             IFID_flush,
  output logic             IDEX_en,
  output logic             IDEX_bubble,
  output logic             EXMEM_en,
  output logic             MEMWB_en,
  output logic             halt_out,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  state_t        state;
  logic [DW-1:0] drain_cnt;
  logic          stall_id;
  logic          active;
  logic          stall_inc;
  logic          flush_inc;

  // A redirect must wait for the in-flight fetch to complete
  assign stall_id = hazard_stall | (branchJumpDTaken_ID & imem_stall);
  assign active   = !rst && !err && (state != HALTED);

  assign stall_inc = active && (dmem_stall || (state == RUN && stall_id));
  assign flush_inc = active && state == RUN && !dmem_stall && !stall_id &&
                     !halt_ID && branchJumpDTaken_ID;

  assign halt_out = (state == HALTED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      drain_cnt <= '0;
    end else if (err) begin
      state <= HALTED;
    end else begin
      case (state)
        RUN: begin
          if (!dmem_stall && !stall_id && halt_ID) begin
            state     <= DRAIN;
            drain_cnt <= DW'(DRAIN_CYCLES);
          end
        end
        DRAIN: begin
          if (!dmem_stall) begin
            drain_cnt <= drain_cnt - 1'b1;
            if (drain_cnt == DW'(1))
              state <= HALTED;
          end
        end
        default: state <= HALTED;
      endcase
    end
  end

  always_comb begin
    PC_en       = 1'b0;
    IFID_en     = 1'b0;
    IFID_flush  = 1'b0;
    IDEX_en     = 1'b0;
    IDEX_bubble = 1'b0;
    EXMEM_en    = 1'b0;
    MEMWB_en    = 1'b0;
    if (active && !dmem_stall) begin
      EXMEM_en = 1'b1;
      MEMWB_en = 1'b1;
      IDEX_en  = 1'b1;
      if (state == DRAIN) begin
        IFID_en     = 1'b1;
        IFID_flush  = 1'b1;
        IDEX_bubble = 1'b1;
      end else if (stall_id) begin
        IDEX_bubble = 1'b1;
      end else if (halt_ID) begin
        IFID_en    = 1'b1;
        IFID_flush = 1'b1;
      end else if (branchJumpDTaken_ID) begin
        PC_en      = 1'b1;
        IFID_en    = 1'b1;
        IFID_flush = 1'b1;
      end else if (imem_stall) begin
        IFID_en    = 1'b1;
        IFID_flush = 1'b1;
      end else begin
        PC_en   = 1'b1;
        IFID_en = 1'b1;
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .count (flush_count)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a behavioural model queues the expected
// outputs for each driven cycle, a monitor compares them mid-cycle.
module tb_pipe_ctrl;

  localparam int CW  = 4;
  localparam int DC  = 3;
  localparam int MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hazard_stall = 0, branchJumpDTaken_ID = 0, halt_ID = 0;
  logic imem_stall = 0, dmem_stall = 0, err = 0;
  logic PC_en, IFID_en, IFID_flush, IDEX_en, IDEX_bubble, EXMEM_en, MEMWB_en;
  logic halt_out;
  logic [CW-1:0] stall_cycles, flush_count;

  pipe_ctrl #(.CNT_W(CW), .DRAIN_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .hazard_stall(hazard_stall),
    .branchJumpDTaken_ID(branchJumpDTaken_ID), .halt_ID(halt_ID),
    .imem_stall(imem_stall), .dmem_stall(dmem_stall), .err(err),
    .PC_en(PC_en), .IFID_en(IFID_en), .IFID_flush(IFID_flush),
    .IDEX_en(IDEX_en), .IDEX_bubble(IDEX_bubble), .EXMEM_en(EXMEM_en),
    .MEMWB_en(MEMWB_en), .halt_out(halt_out),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]    ctl;   // pc, ifid, ifid_flush, idex, bubble, exmem, memwb, halt
    logic [CW-1:0] stall;
    logic [CW-1:0] flush;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   done = 0;

  // model: halted flag, remaining drain cycles (0 = not draining), counters
  bit m_halted;
  int m_drain_left;
  int m_stall, m_flush;

  task automatic model_reset();
    m_halted = 0; m_drain_left = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic step(input logic r, hz, br, hl, im, dm, er);
    exp_t e;
    bit   sid;
    @(posedge clk);
    #1;
    rst = r; hazard_stall = hz; branchJumpDTaken_ID = br; halt_ID = hl;
    imem_stall = im; dmem_stall = dm; err = er;
    sid = hz | (br & im);
    e.stall = CW'(m_stall);
    e.flush = CW'(m_flush);
    if (r) begin
      e = '0;
      model_reset();
    end else begin
      if (er || m_halted || dm)  e.ctl = 8'b0000_0000;
      else if (m_drain_left > 0) e.ctl = 8'b0111_1110;
      else if (sid)              e.ctl = 8'b0001_1110;
      else if (hl)               e.ctl = 8'b0111_0110;
      else if (br)               e.ctl = 8'b1111_0110;
      else if (im)               e.ctl = 8'b0111_0110;
      else                       e.ctl = 8'b1101_0110;
      e.ctl[0] = m_halted;
      // state advance at the coming clock edge
      if (er) begin
        m_halted = 1; m_drain_left = 0;
      end else if (!m_halted) begin
        if (dm) begin
          if (m_stall < MAX) m_stall++;
        end else if (m_drain_left > 0) begin
          m_drain_left--;
          if (m_drain_left == 0) m_halted = 1;
        end else if (sid) begin
          if (m_stall < MAX) m_stall++;
        end else if (hl) begin
          m_drain_left = DC;
        end else if (br) begin
          if (m_flush < MAX) m_flush++;
        end
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a.ctl   = {PC_en, IFID_en, IFID_flush, IDEX_en, IDEX_bubble,
                   EXMEM_en, MEMWB_en, halt_out};
        a.stall = stall_cycles;
        a.flush = flush_count;
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL cycle_out t=%0t got ctl=%b stall=%0d flush=%0d exp ctl=%b stall=%0d flush=%0d",
                   $time, a.ctl, a.stall, a.flush, e.ctl, e.stall, e.flush);
        end
      end
    end
  end

  initial begin : driver
    model_reset();
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    idle(2);
    // hazard for two cycles
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    idle(1);
    // branch waiting on fetch, then redirect
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    idle(1);
    // halt, then data stalls during drain
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    idle(6);
    // async reset out of HALTED, then halt and branch together
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0, 0);
    step(0, 1, 1, 1, 0, 0, 0);
    idle(4);
    // saturation
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 0, 0, 0);
    idle(1);
    // err in RUN
    step(0, 0, 0, 0, 0, 0, 1);
    idle(2);
    // mid-drain reset
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    idle(1);
    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 39) == 0),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 99) == 0));
    end
    idle(1);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_queue got %0d pending exp 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
